mem_stage_top: RTL and testbench

Memory stage of the 5-stage RV32I pipeline. Consumes the EX stage outputs (alu_result, rs2_out, rd_out, mem/wb control) and latches them in an EX/MEM register. It performs byte-enabled load/store to a synchronous data memory and presents registered MEM/WB results to write-back. It also exports the EX/MEM fields that the forwarding unit needs.

---
 rtl/riscv_pkg.sv | 110 +++++++++++
 rtl/data_mem.sv | 37 +++
 rtl/mem_stage_top.sv | 148 ++++++++++++++
 tb/tb_mem_stage_top.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage.
//
// Contents:
//   XLEN                 architectural register width
//   F3_* constants       funct3 encodings for loads and stores
//   exmem_t / memwb_t    pipeline register layouts
//   is_misaligned()      alignment check for a memory access
//   store_be()           byte-enable generation for SB/SH/SW
//   store_data()         lane replication of store data
//   load_extend()        byte/half extraction and sign/zero extension
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } exmem_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [1:0]      addr_lo;
        logic            use_load;   // wb_data comes from memory, not the ALU
        logic            reg_write;
        logic            misalign;
    } memwb_t;

    // Only the widths that actually exist for each direction are checked;
    // a store with a non-store funct3 never writes, so it never faults.
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic half_bad;
        logic word_bad;
        half_bad = addr_lo[0];
        word_bad = (addr_lo != 2'b00);
        is_misaligned = 1'b0;
        if (is_load) begin
            case (f3)
                F3_LH, F3_LHU: is_misaligned = half_bad;
                F3_LW:         is_misaligned = word_bad;
                default:       is_misaligned = 1'b0;
            endcase
        end else if (is_store) begin
            case (f3)
                F3_SH:   is_misaligned = half_bad;
                F3_SW:   is_misaligned = word_bad;
                default: is_misaligned = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
        case (f3)
            F3_SB:   store_be = 4'b0001 << addr_lo;
            F3_SH:   store_be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_SW:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Data is replicated into every lane so the byte enables alone pick
    // the destination bytes.
    function automatic logic [XLEN-1:0] store_data(input logic [2:0]      f3,
                                                   input logic [XLEN-1:0] rs2);
        case (f3)
            F3_SB:   store_data = {4{rs2[7:0]}};
            F3_SH:   store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                    input logic [1:0]      addr_lo,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   load_extend = {{24{b[7]}}, b};
            F3_LBU:  load_extend = {24'd0, b};
            F3_LH:   load_extend = {{16{h[15]}}, h};
            F3_LHU:  load_extend = {16'd0, h};
            F3_LW:   load_extend = word;
            default: load_extend = '0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem.sv
// Synchronous single-port data RAM with per-byte write enables.
//
// Ports:
//   clk     rising-edge clock
//   rd_en   capture mem[idx] into rdata on this edge
//   we      byte write enables (bit i writes wdata[8i+7:8i])
//   idx     word index
//   wdata   write data, already lane-aligned
//   rdata   registered read data (value before any same-edge write)
module data_mem #(
    parameter int DMEM_WORDS = 1024,
    parameter int IDX_W      = $clog2(DMEM_WORDS)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DMEM_WORDS];

    // NOTE: the array and rdata have no reset so the RAM maps onto block
    // memory; nothing downstream consumes rdata until a load has been read.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_stage_top.sv
// MEM stage of a 5-stage RV32I pipeline: EX/MEM register, byte-enabled
// data memory access, MEM/WB register and write-back selection.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                hold EX/MEM and MEM/WB, suppress store
//   flush                load a bubble into EX/MEM
//   alu_result           EX result / memory byte address
//   rs2_out              store data
//   rd_out               destination register
//   funct3               load/store width and sign
//   reg_write, mem_read, mem_write, mem_to_reg   EX control
//   exmem_alu_result, exmem_rd, exmem_reg_write  forwarding taps
//   wb_data, wb_rd, wb_reg_write                 write-back interface
//   misalign_err         faulting access now in MEM/WB
module mem_stage_top
    import riscv_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int IDX_W      = $clog2(DMEM_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_out,
    input  logic [4:0]      rd_out,
    input  logic [2:0]      funct3,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    output logic [XLEN-1:0] exmem_alu_result,
    output logic [4:0]      exmem_rd,
    output logic            exmem_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            misalign_err
);

    exmem_t exmem_q;
    memwb_t memwb_q;

    logic            ex_is_load;
    logic            ex_is_store;
    logic            ex_misalign;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    // NOTE: pipeline state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_q <= '0;
        end else if (!stall) begin
            if (flush) begin
                exmem_q <= '0;
            end else begin
                exmem_q <= '{alu_result: alu_result,
                             rs2:        rs2_out,
                             rd:         rd_out,
                             funct3:     funct3,
                             reg_write:  reg_write,
                             mem_read:   mem_read,
                             mem_write:  mem_write,
                             mem_to_reg: mem_to_reg};
            end
        end
    end

    // A simultaneous read+write request is treated as a store.
    assign ex_is_store = exmem_q.mem_write;
    assign ex_is_load  = exmem_q.mem_read & ~exmem_q.mem_write;
    assign ex_misalign = is_misaligned(ex_is_load, ex_is_store,
                                       exmem_q.funct3, exmem_q.alu_result[1:0]);

    // ------------------------------------------------------------------
    // Data memory access
    // ------------------------------------------------------------------
    // Upper address bits are dropped, so addresses alias modulo the depth.
    assign mem_idx   = exmem_q.alu_result[IDX_W+1:2];
    assign mem_wdata = store_data(exmem_q.funct3, exmem_q.rs2);
    // Reset on the commit edge also kills the write.
    assign mem_be    = (ex_is_store && !ex_misalign && !stall && !rst)
                     ? store_be(exmem_q.funct3, exmem_q.alu_result[1:0])
                     : 4'b0000;

    data_mem #(
        .DMEM_WORDS (DMEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rd_en (!stall),
        .we    (mem_be),
        .idx   (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    // The RAM read port is also gated by stall, so mem_rdata stays paired
    // with the held MEM/WB fields while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_q <= '0;
        end else if (!stall) begin
            memwb_q <= '{alu_result: exmem_q.alu_result,
                         rd:         exmem_q.rd,
                         funct3:     exmem_q.funct3,
                         addr_lo:    exmem_q.alu_result[1:0],
                         use_load:   exmem_q.mem_to_reg & ~exmem_q.mem_write,
                         reg_write:  exmem_q.reg_write,
                         misalign:   ex_misalign};
        end
    end

    // ------------------------------------------------------------------
    // Write-back selection
    // ------------------------------------------------------------------
    // NOTE: wb_data gets a default before any conditional update, so the
    // block is purely combinational with no inferred latch.
    always_comb begin
        wb_data = memwb_q.alu_result;
        if (memwb_q.use_load) begin
            wb_data = memwb_q.misalign
                    ? '0
                    : load_extend(memwb_q.funct3, memwb_q.addr_lo, mem_rdata);
        end
    end

    assign wb_rd        = memwb_q.rd;
    assign wb_reg_write = memwb_q.reg_write & (memwb_q.rd != 5'd0) & ~memwb_q.misalign;
    assign misalign_err = memwb_q.misalign;

    assign exmem_alu_result = exmem_q.alu_result;
    assign exmem_rd         = exmem_q.rd;
    assign exmem_reg_write  = exmem_q.reg_write & (exmem_q.rd != 5'd0);

endmodule

// File: tb/tb_mem_stage_top.sv
// Directed self-checking bench for mem_stage_top.
module tb_mem_stage_top;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SW  = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] alu_result;
    logic [31:0] rs2_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] exmem_alu_result;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    mem_stage_top #(.DMEM_WORDS(1024)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .alu_result       (alu_result),
        .rs2_out          (rs2_out),
        .rd_out           (rd_out),
        .funct3           (funct3),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_to_reg       (mem_to_reg),
        .exmem_alu_result (exmem_alu_result),
        .exmem_rd         (exmem_rd),
        .exmem_reg_write  (exmem_reg_write),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .wb_reg_write     (wb_reg_write),
        .misalign_err     (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic [2:0] f,
                         input logic rw, input logic mr, input logic mw,
                         input logic m2r);
        alu_result = a;
        rs2_out    = d;
        rd_out     = r;
        funct3     = f;
        reg_write  = rw;
        mem_read   = mr;
        mem_write  = mw;
        mem_to_reg = m2r;
    endtask

    task automatic nop();
        issue(32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        issue(a, d, 5'd0, SW, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [4:0] r, input logic [2:0] f);
        issue(a, 32'd0, r, f, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset with live inputs ----------------
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        issue(32'h123, 32'h456, 5'd9, LW, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'h0);
        check("rst_wb_rw", {31'd0, wb_reg_write}, 32'h0);
        check("rst_misalign", {31'd0, misalign_err}, 32'h0);
        check("rst_exmem_alu", exmem_alu_result, 32'h0);
        check("rst_exmem_rd", {27'd0, exmem_rd}, 32'h0);
        check("rst_exmem_rw", {31'd0, exmem_reg_write}, 32'h0);
        rst = 1'b0;

        // ---------------- SW then back-to-back LW ----------------
        st(32'h40, 32'hDEADBEEF); tick();
        ld(32'h40, 5'd5, LW); tick();
        check("lw_exmem_alu", exmem_alu_result, 32'h40);
        check("lw_exmem_rd", {27'd0, exmem_rd}, 32'd5);
        check("lw_exmem_rw", {31'd0, exmem_reg_write}, 32'd1);
        nop(); tick();
        check("lw_wb_data", wb_data, 32'hDEADBEEF);
        check("lw_wb_rd", {27'd0, wb_rd}, 32'd5);
        check("lw_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        check("lw_misalign", {31'd0, misalign_err}, 32'd0);

        // ---------------- byte/half extension ----------------
        st(32'h10, 32'h80FF7F01); tick();
        ld(32'h13, 5'd6, LB);  tick();
        ld(32'h13, 5'd6, LBU); tick();
        check("lb_0x13", wb_data, 32'hFFFFFF80);
        ld(32'h12, 5'd6, LH);  tick();
        check("lbu_0x13", wb_data, 32'h00000080);
        ld(32'h10, 5'd6, LHU); tick();
        check("lh_0x12", wb_data, 32'hFFFF80FF);
        nop(); tick();
        check("lhu_0x10", wb_data, 32'h00007F01);

        // ---------------- SB lane placement ----------------
        st(32'h20, 32'h0); tick();
        issue(32'h22, 32'h001234AB, 5'd0, SB, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        ld(32'h20, 5'd7, LW); tick();
        nop(); tick();
        check("sb_lane", wb_data, 32'h00AB0000);

        // ---------------- misaligned accesses ----------------
        ld(32'h41, 5'd3, LW); tick();
        nop(); tick();
        check("mis_lw_flag", {31'd0, misalign_err}, 32'd1);
        check("mis_lw_rw", {31'd0, wb_reg_write}, 32'd0);
        check("mis_lw_data", wb_data, 32'h0);
        check("mis_lw_rd", {27'd0, wb_rd}, 32'd3);
        tick();
        check("mis_one_cycle", {31'd0, misalign_err}, 32'd0);
        st(32'h42, 32'hFFFFFFFF); tick();
        ld(32'h40, 5'd5, LW); tick();
        check("mis_sw_flag", {31'd0, misalign_err}, 32'd1);
        nop(); tick();
        check("mis_sw_suppressed", wb_data, 32'hDEADBEEF);
        ld(32'h13, 5'd3, LHU); tick();
        nop(); tick();
        check("mis_lhu_flag", {31'd0, misalign_err}, 32'd1);

        // ---------------- address wrap ----------------
        ld(32'h1040, 5'd9, LW); tick();
        nop(); tick();
        check("wrap_alias", wb_data, 32'hDEADBEEF);

        // ---------------- stall ----------------
        st(32'h30, 32'h11); tick();
        issue(32'h77, 32'h0, 5'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        st(32'h30, 32'h55); tick();
        check("stall_pre_wb", wb_data, 32'h77);
        stall = 1'b1; flush = 1'b1; nop(); tick();
        check("stall1_wb_data", wb_data, 32'h77);
        check("stall1_wb_rd", {27'd0, wb_rd}, 32'd7);
        check("stall1_exmem", exmem_alu_result, 32'h30);
        check("stall1_mem", dut.u_mem.mem[12], 32'h11);
        tick();
        check("stall2_wb_data", wb_data, 32'h77);
        check("stall2_mem", dut.u_mem.mem[12], 32'h11);
        stall = 1'b0; flush = 1'b0;
        ld(32'h30, 5'd2, LW); tick();
        check("release_mem", dut.u_mem.mem[12], 32'h55);
        nop(); tick();
        check("release_load", wb_data, 32'h55);

        // ---------------- flush ----------------
        flush = 1'b1;
        issue(32'h30, 32'h99, 5'd4, SW, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        flush = 1'b0;
        check("flush_exmem_rw", {31'd0, exmem_reg_write}, 32'd0);
        check("flush_exmem_alu", exmem_alu_result, 32'h0);
        ld(32'h30, 5'd2, LW); tick();
        nop(); tick();
        check("flush_no_store", wb_data, 32'h55);

        // ---------------- ALU pass-through and x0 ----------------
        issue(32'd30, 32'd0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        nop(); tick();
        check("alu_wb_data", wb_data, 32'd30);
        check("alu_wb_rd", {27'd0, wb_rd}, 32'd3);
        check("alu_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        issue(32'd30, 32'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        check("x0_exmem_rw", {31'd0, exmem_reg_write}, 32'd0);
        nop(); tick();
        check("x0_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        check("x0_wb_data", wb_data, 32'd30);

        // ---------------- mem_read and mem_write together ----------------
        issue(32'h50, 32'h0000CAFE, 5'd8, SW, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        ld(32'h50, 5'd8, LW); tick();
        check("rw_both_wb_alu", wb_data, 32'h50);
        check("rw_both_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        nop(); tick();
        check("rw_both_stored", wb_data, 32'h0000CAFE);

        // ---------------- reset mid-store ----------------
        st(32'h60, 32'h1234); tick();
        issue(32'hAA, 32'h0, 5'd9, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        st(32'h60, 32'hBBBB); tick();
        check("pre_rst_wb", wb_data, 32'hAA);
        rst = 1'b1; nop(); tick();
        check("midrst_wb_data", wb_data, 32'h0);
        check("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("midrst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        check("midrst_exmem_alu", exmem_alu_result, 32'h0);
        rst = 1'b0;
        ld(32'h60, 5'd2, LW); tick();
        nop(); tick();
        check("midrst_store_killed", wb_data, 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
